// File: rtl/outport_uart_tx_if.sv
// Write-port and status bundle between the CPU output-port register and the UART TX stage.
interface outport_uart_tx_if;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        full;
  logic        empty;
  logic        busy;
  logic        overflow;
  logic        tx;

  modport master (output wr_en, output wr_data,
                  input full, input empty, input busy, input overflow, input tx);
  modport slave  (input wr_en, input wr_data,
                  output full, output empty, output busy, output overflow, output tx);
endinterface

// File: rtl/outport_uart_tx.sv
// Output-port word FIFO feeding a UART transmitter, four bytes per word, LSB first.
// Optional even-parity bit per byte when OUTPORT_UART_TX_PARITY_EN is defined (8E1, else 8N1).
module outport_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic               clock,
  input  logic               clear,
  outport_uart_tx_if.slave   bus
);

  localparam int unsigned CNT_W  = $clog2(CLKS_PER_BIT);
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned FCNT_W = PTR_W + 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd3;
`ifdef OUTPORT_UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd4;
`endif

  logic [31:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [FCNT_W-1:0] count_q, count_n;
  logic              full_q, empty_q, busy_q, overflow_q, tx_q;

  logic [2:0]        state_q, state_n;
  logic [CNT_W-1:0]  cnt_q, cnt_n;
  logic [2:0]        bit_q, bit_n;
  logic [1:0]        byte_q, byte_n;
  logic [31:0]       sh_q, sh_n;
  logic [7:0]        cur_byte_n;
  logic              tx_n;
  logic              push, pop, tick;

  assign push = bus.wr_en & ~full_q;
  assign tick = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

  // Next-state, pop request and registered-output values
  always_comb begin
    state_n    = state_q;
    cnt_n      = '0;
    bit_n      = bit_q;
    byte_n     = byte_q;
    sh_n       = sh_q;
    pop        = 1'b0;
    tx_n       = 1'b1;
    cur_byte_n = '0;

    case (state_q)
      S_IDLE: begin
        if (!empty_q) begin
          pop     = 1'b1;
          sh_n    = mem[rd_ptr_q];
          byte_n  = 2'd0;
          state_n = S_START;
        end
      end
      S_START: begin
        if (tick) begin
          state_n = S_DATA;
          bit_n   = 3'd0;
        end
      end
      S_DATA: begin
        if (tick) begin
          if (bit_q == 3'd7) begin
`ifdef OUTPORT_UART_TX_PARITY_EN
            state_n = S_PARITY;
`else
            state_n = S_STOP;
`endif
          end else begin
            bit_n = bit_q + 3'd1;
          end
        end
      end
`ifdef OUTPORT_UART_TX_PARITY_EN
      S_PARITY: begin
        if (tick) state_n = S_STOP;
      end
`endif
      S_STOP: begin
        if (tick) begin
          if (byte_q != 2'd3) begin
            byte_n  = byte_q + 2'd1;
            sh_n    = sh_q >> 8;
            state_n = S_START;
          end else if (!empty_q) begin
            // back-to-back word: no idle cycle between frames
            pop     = 1'b1;
            sh_n    = mem[rd_ptr_q];
            byte_n  = 2'd0;
            state_n = S_START;
          end else begin
            state_n = S_IDLE;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase

    if (state_q != S_IDLE && !tick) cnt_n = cnt_q + CNT_W'(1);

    cur_byte_n = sh_n[7:0];
    case (state_n)
      S_START:  tx_n = 1'b0;
      S_DATA:   tx_n = cur_byte_n[bit_n];
`ifdef OUTPORT_UART_TX_PARITY_EN
      S_PARITY: tx_n = ^cur_byte_n;
`endif
      default:  tx_n = 1'b1;
    endcase

    case ({push, pop})
      2'b10:   count_n = count_q + FCNT_W'(1);
      2'b01:   count_n = count_q - FCNT_W'(1);
      default: count_n = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      byte_q     <= '0;
      sh_q       <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_n;
      cnt_q      <= cnt_n;
      bit_q      <= bit_n;
      byte_q     <= byte_n;
      sh_q       <= sh_n;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q    <= count_n;
      full_q     <= (count_n == FCNT_W'(FIFO_DEPTH));
      empty_q    <= (count_n == '0);
      busy_q     <= (state_n != S_IDLE);
      overflow_q <= overflow_q | (bus.wr_en & full_q);
      tx_q       <= tx_n;
    end
  end

  // Storage needs no reset; contents are only read behind a valid count
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr_q] <= bus.wr_data;
  end

  assign bus.full     = full_q;
  assign bus.empty    = empty_q;
  assign bus.busy     = busy_q;
  assign bus.overflow = overflow_q;
  assign bus.tx       = tx_q;

endmodule
